// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between imem (req/ack) and the datapath (valid/ready).
// Optional macro FETCH_QUEUE_STATS_EN adds the 16-bit flushCount output.
//
// Ports:
//   clock, reset             clock and synchronous active-high reset
//   redirect, redirectPC     one-cycle flush pulse and new fetch target
//   memReq, memAddr          fetch request and its word address
//   memAck, memData          request accepted and returned word (same cycle)
//   instrValid, instr,       head entry and its word and PC
//   instrPC
//   instrReady               datapath consumes the head entry
//   count                    number of occupied entries
//   flushCount               (stats build only) total entries discarded by redirects
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [31:0]              redirectPC,
    output logic                     memReq,
    output logic [31:0]              memAddr,
    input  logic                     memAck,
    input  logic [31:0]              memData,
    output logic                     instrValid,
    output logic [31:0]              instr,
    output logic [31:0]              instrPC,
    input  logic                     instrReady,
`ifdef FETCH_QUEUE_STATS_EN
    output logic [15:0]              flushCount,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        FETCH  = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t         state;
    logic [31:0]    fetchPC;
    logic [PW-1:0]  rdPtr;
    logic [PW-1:0]  wrPtr;
    logic [CW-1:0]  cnt;
    logic [31:0]    pcMem   [DEPTH];
    logic [31:0]    wordMem [DEPTH];

    logic full;
    logic push;
    logic pop;

    assign full       = (cnt == CW'(DEPTH));
    assign memReq     = (state == FETCH) && !full && !redirect && !reset;
    assign push       = memReq && memAck;
    assign instrValid = (cnt != '0) && !reset;
    assign pop        = instrValid && instrReady;
    assign instr      = instrValid ? wordMem[rdPtr] : 32'h0;
    assign instrPC    = instrValid ? pcMem[rdPtr] : 32'h0;
    // Before the first reset edge fetchPC/cnt are unknown; mask them while reset is high.
    assign memAddr    = reset ? RESET_PC : fetchPC;
    assign count      = reset ? '0 : cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= FETCH;
            fetchPC <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            cnt     <= '0;
        end else if (redirect) begin
            state   <= BUBBLE;
            fetchPC <= redirectPC & ~32'h3;
            rdPtr   <= '0;
            wrPtr   <= '0;
            cnt     <= '0;
        end else begin
            state <= FETCH;
            if (push) begin
                wrPtr   <= wrPtr + PW'(1);
                fetchPC <= fetchPC + 32'd4;
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // push already excludes redirect and reset cycles
    always_ff @(posedge clock) begin
        if (push) begin
            pcMem[wrPtr]   <= fetchPC;
            wordMem[wrPtr] <= memData;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [CW-1:0] discarded;
    logic [16:0]   flushSum;

    // the entry popped in the redirect cycle is delivered, not discarded
    assign discarded = cnt - (pop ? CW'(1) : CW'(0));
    assign flushSum  = {1'b0, flushCount} + 17'(discarded);

    always_ff @(posedge clock) begin
        if (reset) begin
            flushCount <= '0;
        end else if (redirect) begin
            flushCount <= flushSum[16] ? 16'hFFFF : flushSum[15:0];
        end
    end
`endif

endmodule
